// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings, pipeline-control state enum and hazard bundle.
// Used by fetch, the other pipeline stages and pipe_ctrl.
package y86_pkg;

    localparam int unsigned ADDR_W  = 64;
    localparam int unsigned ICODE_W = 4;
    localparam int unsigned STAT_W  = 3;
    localparam int unsigned REG_W   = 4;

    localparam logic [ICODE_W-1:0] I_HALT  = 4'h0;
    localparam logic [ICODE_W-1:0] I_NOP   = 4'h1;
    localparam logic [ICODE_W-1:0] I_CMOV  = 4'h2;
    localparam logic [ICODE_W-1:0] I_IRMOV = 4'h3;
    localparam logic [ICODE_W-1:0] I_RMMOV = 4'h4;
    localparam logic [ICODE_W-1:0] I_MRMOV = 4'h5;
    localparam logic [ICODE_W-1:0] I_OPQ   = 4'h6;
    localparam logic [ICODE_W-1:0] I_JXX   = 4'h7;
    localparam logic [ICODE_W-1:0] I_CALL  = 4'h8;
    localparam logic [ICODE_W-1:0] I_RET   = 4'h9;
    localparam logic [ICODE_W-1:0] I_PUSH  = 4'hA;
    localparam logic [ICODE_W-1:0] I_POP   = 4'hB;

    localparam logic [STAT_W-1:0] S_AOK = 3'd1;
    localparam logic [STAT_W-1:0] S_HLT = 3'd2;
    localparam logic [STAT_W-1:0] S_ADR = 3'd3;
    localparam logic [STAT_W-1:0] S_INS = 3'd4;

    localparam logic [REG_W-1:0] R_NONE = 4'hF;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } pipe_state_e;

    typedef struct packed {
        logic loaduse;
        logic retp;
        logic mispred;
        logic mexc;
        logic wexc;
    } hazard_t;

    // Only the three defined exception codes count; AOK and undefined codes do not.
    function automatic logic is_exc(input logic [STAT_W-1:0] stat);
        return (stat == S_HLT) || (stat == S_ADR) || (stat == S_INS);
    endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Pipeline-control bus: stage state into pipe_ctrl, fetch PC and register controls out.
// master = datapath side, slave = pipe_ctrl.
interface pipe_ctrl_if;
    import y86_pkg::*;

    logic [ADDR_W-1:0]  f_predPC;
    logic [ICODE_W-1:0] M_icode;
    logic               M_Cnd;
    logic [ADDR_W-1:0]  M_valA;
    logic [ICODE_W-1:0] W_icode;
    logic [ADDR_W-1:0]  W_valM;
    logic [ICODE_W-1:0] D_icode;
    logic [ICODE_W-1:0] E_icode;
    logic [REG_W-1:0]   E_dstM;
    logic               e_Cnd;
    logic [REG_W-1:0]   d_srcA;
    logic [REG_W-1:0]   d_srcB;
    logic [STAT_W-1:0]  m_stat;
    logic [STAT_W-1:0]  W_stat;

    logic [ADDR_W-1:0]  f_pc;
    logic [ADDR_W-1:0]  F_predPC;
    logic               F_stall;
    logic               D_stall;
    logic               D_bubble;
    logic               E_bubble;
    logic               M_bubble;
    logic               W_stall;
    logic               set_cc;
    logic               halted;

    modport master (
        output f_predPC, M_icode, M_Cnd, M_valA, W_icode, W_valM, D_icode,
               E_icode, E_dstM, e_Cnd, d_srcA, d_srcB, m_stat, W_stat,
        input  f_pc, F_predPC, F_stall, D_stall, D_bubble, E_bubble,
               M_bubble, W_stall, set_cc, halted
    );

    modport slave (
        input  f_predPC, M_icode, M_Cnd, M_valA, W_icode, W_valM, D_icode,
               E_icode, E_dstM, e_Cnd, d_srcA, d_srcB, m_stat, W_stat,
        output f_pc, F_predPC, F_stall, D_stall, D_bubble, E_bubble,
               M_bubble, W_stall, set_cc, halted
    );

endinterface

// File: rtl/pipe_hazard_detect.sv
// Combinational hazard terms: load-use, ret in flight, mispredict, M/W exceptions.
module pipe_hazard_detect
    import y86_pkg::*;
(
    input  logic [ICODE_W-1:0] D_icode,
    input  logic [ICODE_W-1:0] E_icode,
    input  logic [ICODE_W-1:0] M_icode,
    input  logic [REG_W-1:0]   E_dstM,
    input  logic [REG_W-1:0]   d_srcA,
    input  logic [REG_W-1:0]   d_srcB,
    input  logic               e_Cnd,
    input  logic [STAT_W-1:0]  m_stat,
    input  logic [STAT_W-1:0]  W_stat,
    output hazard_t            hz
);

    always_comb begin
        hz = '0;
        hz.loaduse = ((E_icode == I_MRMOV) || (E_icode == I_POP)) &&
                     (E_dstM != R_NONE) &&
                     ((E_dstM == d_srcA) || (E_dstM == d_srcB));
        hz.retp    = (D_icode == I_RET) || (E_icode == I_RET) || (M_icode == I_RET);
        hz.mispred = (E_icode == I_JXX) && !e_Cnd;
        hz.mexc    = is_exc(m_stat);
        hz.wexc    = is_exc(W_stat);
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Y86-64 pipeline control: predicted-PC register, fetch-PC select, stall/bubble
// controls and RUN/HALTED FSM. Define PIPE_PERF_EN to add performance counters.
module pipe_ctrl
    import y86_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = 64'd0,
    parameter int unsigned       CNT_W    = 32
) (
    input  logic            clk,
    input  logic            reset,
    pipe_ctrl_if.slave      pif
`ifdef PIPE_PERF_EN
    ,
    output logic [CNT_W-1:0] perf_cycles,
    output logic [CNT_W-1:0] perf_stalls,
    output logic [CNT_W-1:0] perf_mispred
`endif
);

    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("pipe_ctrl: CNT_W must be at least 1");
    end

    hazard_t           hz;
    pipe_state_e       state_q;
    pipe_state_e       state_d;
    logic [ADDR_W-1:0] pred_pc_q;

    pipe_hazard_detect u_hazard (
        .D_icode (pif.D_icode),
        .E_icode (pif.E_icode),
        .M_icode (pif.M_icode),
        .E_dstM  (pif.E_dstM),
        .d_srcA  (pif.d_srcA),
        .d_srcB  (pif.d_srcB),
        .e_Cnd   (pif.e_Cnd),
        .m_stat  (pif.m_stat),
        .W_stat  (pif.W_stat),
        .hz      (hz)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and register controls; HALTED freezes fetch/decode/writeback.
    always_comb begin
        state_d      = state_q;
        pif.F_stall  = 1'b0;
        pif.D_stall  = 1'b0;
        pif.D_bubble = 1'b0;
        pif.E_bubble = 1'b0;
        pif.M_bubble = 1'b0;
        pif.W_stall  = 1'b0;
        pif.set_cc   = 1'b0;
        pif.halted   = 1'b0;
        case (state_q)
            ST_RUN: begin
                pif.F_stall  = hz.loaduse | hz.retp;
                pif.D_stall  = hz.loaduse;
                pif.D_bubble = hz.mispred | (!hz.loaduse & hz.retp);
                pif.E_bubble = hz.mispred | hz.loaduse;
                pif.M_bubble = hz.mexc | hz.wexc;
                pif.W_stall  = hz.wexc;
                pif.set_cc   = (pif.E_icode == I_OPQ) & !hz.mexc & !hz.wexc;
                if (pif.W_stat != S_AOK) begin
                    state_d = ST_HALTED;
                end
            end
            ST_HALTED: begin
                pif.F_stall  = 1'b1;
                pif.D_stall  = 1'b1;
                pif.W_stall  = 1'b1;
                pif.M_bubble = 1'b1;
                pif.halted   = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pred_pc_q <= RESET_PC;
        end else if (!pif.F_stall) begin
            pred_pc_q <= pif.f_predPC;
        end
    end

    // Mispredict recovery outranks ret target, which outranks the prediction.
    always_comb begin
        if ((pif.M_icode == I_JXX) && !pif.M_Cnd) begin
            pif.f_pc = pif.M_valA;
        end else if (pif.W_icode == I_RET) begin
            pif.f_pc = pif.W_valM;
        end else begin
            pif.f_pc = pred_pc_q;
        end
    end

    assign pif.F_predPC = pred_pc_q;

`ifdef PIPE_PERF_EN
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        return (en && (v != '1)) ? v + CNT_W'(1) : v;
    endfunction

    // Counters advance only in RUN and stick at all-ones.
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_cycles  <= '0;
            perf_stalls  <= '0;
            perf_mispred <= '0;
        end else if (state_q == ST_RUN) begin
            perf_cycles  <= sat_inc(perf_cycles, 1'b1);
            perf_stalls  <= sat_inc(perf_stalls, pif.F_stall);
            perf_mispred <= sat_inc(perf_mispred, hz.mispred);
        end
    end
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed walk through the main hazards, then random
// stimulus compared each cycle against a behavioural model of the control rules.
module tb_pipe_ctrl;
    import y86_pkg::*;

    localparam logic [63:0] RESET_PC = 64'd0;
    localparam int unsigned CNT_W    = 32;

    logic clk = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    pipe_ctrl_if pif ();

`ifdef PIPE_PERF_EN
    logic [CNT_W-1:0] perf_cycles, perf_stalls, perf_mispred;
    logic [CNT_W-1:0] m_cycles, m_stalls, m_mispred;
`endif

    pipe_ctrl #(.RESET_PC(RESET_PC), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .pif   (pif)
`ifdef PIPE_PERF_EN
        ,
        .perf_cycles  (perf_cycles),
        .perf_stalls  (perf_stalls),
        .perf_mispred (perf_mispred)
`endif
    );

    logic [63:0] m_pred;
    logic        m_halted;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_idle();
        pif.f_predPC = 64'd0;
        pif.M_icode  = I_NOP;
        pif.M_Cnd    = 1'b1;
        pif.M_valA   = 64'd0;
        pif.W_icode  = I_NOP;
        pif.W_valM   = 64'd0;
        pif.D_icode  = I_NOP;
        pif.E_icode  = I_NOP;
        pif.E_dstM   = R_NONE;
        pif.e_Cnd    = 1'b1;
        pif.d_srcA   = R_NONE;
        pif.d_srcB   = R_NONE;
        pif.m_stat   = S_AOK;
        pif.W_stat   = S_AOK;
    endtask

    // Called just after a falling edge with inputs applied: check, clock, update model.
    task automatic step();
        logic       lu, rp, mp, me, we;
        logic [7:0] exp_ctrl, obs_ctrl;
        logic [63:0] exp_fpc;
        #1;
        lu = ((pif.E_icode == 4'd5) || (pif.E_icode == 4'd11)) && (pif.E_dstM != 4'd15) &&
             ((pif.E_dstM == pif.d_srcA) || (pif.E_dstM == pif.d_srcB));
        rp = (pif.D_icode == 4'd9) || (pif.E_icode == 4'd9) || (pif.M_icode == 4'd9);
        mp = (pif.E_icode == 4'd7) && !pif.e_Cnd;
        me = (pif.m_stat >= 3'd2) && (pif.m_stat <= 3'd4);
        we = (pif.W_stat >= 3'd2) && (pif.W_stat <= 3'd4);
        // order: F_stall D_stall D_bubble E_bubble M_bubble W_stall set_cc halted
        if (m_halted)
            exp_ctrl = 8'b1100_1101;
        else
            exp_ctrl = {lu | rp, lu, mp | (!lu & rp), mp | lu, me | we, we,
                        (pif.E_icode == 4'd6) & !me & !we, 1'b0};
        obs_ctrl = {pif.F_stall, pif.D_stall, pif.D_bubble, pif.E_bubble,
                    pif.M_bubble, pif.W_stall, pif.set_cc, pif.halted};
        if ((pif.M_icode == 4'd7) && !pif.M_Cnd) exp_fpc = pif.M_valA;
        else if (pif.W_icode == 4'd9)            exp_fpc = pif.W_valM;
        else                                      exp_fpc = m_pred;
        check_val("ctrl", 64'(obs_ctrl), 64'(exp_ctrl));
        check_val("f_pc", pif.f_pc, exp_fpc);
        check_val("F_predPC", pif.F_predPC, m_pred);
        @(posedge clk);
        if (reset) begin
            m_pred   = RESET_PC;
            m_halted = 1'b0;
`ifdef PIPE_PERF_EN
            m_cycles = '0; m_stalls = '0; m_mispred = '0;
`endif
        end else if (!m_halted) begin
            if (!exp_ctrl[7]) m_pred = pif.f_predPC;
`ifdef PIPE_PERF_EN
            if (m_cycles != '1) m_cycles++;
            if (exp_ctrl[7] && m_stalls != '1) m_stalls++;
            if (mp && m_mispred != '1) m_mispred++;
`endif
            if (pif.W_stat != 3'd1) m_halted = 1'b1;
        end
        @(negedge clk);
`ifdef PIPE_PERF_EN
        check_val("perf_cycles", 64'(perf_cycles), 64'(m_cycles));
        check_val("perf_stalls", 64'(perf_stalls), 64'(m_stalls));
        check_val("perf_mispred", 64'(perf_mispred), 64'(m_mispred));
`endif
    endtask

    function automatic logic [3:0] rnd_icode();
        logic [3:0] pick [5];
        pick[0] = I_MRMOV; pick[1] = I_POP; pick[2] = I_JXX; pick[3] = I_RET; pick[4] = I_OPQ;
        if ($urandom_range(0, 9) < 5) return pick[$urandom_range(0, 4)];
        return 4'($urandom_range(0, 15));
    endfunction

    function automatic logic [3:0] rnd_reg();
        int unsigned r = $urandom_range(0, 5);
        return (r == 5) ? R_NONE : 4'(r);
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        set_idle();
        repeat (2) @(posedge clk);
        m_pred   = RESET_PC;
        m_halted = 1'b0;
`ifdef PIPE_PERF_EN
        m_cycles = '0; m_stalls = '0; m_mispred = '0;
`endif
        @(negedge clk);
        reset = 1'b0;
        check_val("rst_pred", pif.F_predPC, RESET_PC);
        check_val("rst_halted", 64'(pif.halted), 64'd0);

        // plain flow
        pif.f_predPC = 64'd10; step(); check_val("pc10", pif.F_predPC, 64'd10);
        pif.f_predPC = 64'd20; step(); check_val("pc20", pif.F_predPC, 64'd20);
        pif.f_predPC = 64'd30; step(); check_val("pc30", pif.F_predPC, 64'd30);
        check_val("fpc_eq_pred", pif.f_pc, 64'd30);

        // load-use
        pif.E_icode = I_MRMOV; pif.E_dstM = 4'd3; pif.d_srcA = 4'd3; pif.f_predPC = 64'd40;
        #1;
        check_val("lu_ctrl", 64'({pif.F_stall, pif.D_stall, pif.E_bubble, pif.D_bubble}), 64'b1110);
        step();
        check_val("lu_hold", pif.F_predPC, 64'd30);

        // mispredict then recovery
        pif.E_icode = I_JXX; pif.e_Cnd = 1'b0; pif.E_dstM = R_NONE; pif.d_srcA = R_NONE;
        #1;
        check_val("mp_ctrl", 64'({pif.D_bubble, pif.E_bubble}), 64'b11);
        step();
        pif.E_icode = I_NOP; pif.e_Cnd = 1'b1;
        pif.M_icode = I_JXX; pif.M_Cnd = 1'b0; pif.M_valA = 64'd64;
        #1;
        check_val("mp_fpc", pif.f_pc, 64'd64);
        step();
        pif.M_icode = I_NOP; pif.M_Cnd = 1'b1;

        // ret in flight, then ret target
        pif.D_icode = I_RET;
        for (int i = 0; i < 3; i++) begin
            #1;
            check_val("ret_ctrl", 64'({pif.F_stall, pif.D_bubble}), 64'b11);
            step();
        end
        pif.D_icode = I_NOP; pif.W_icode = I_RET; pif.W_valM = 64'd76;
        #1;
        check_val("ret_fpc", pif.f_pc, 64'd76);
        check_val("ret_nostall", 64'(pif.F_stall), 64'd0);
        step();
        pif.W_icode = I_NOP;

        // exception, halt, reset out of HALTED
        pif.m_stat = S_ADR; pif.E_icode = I_OPQ;
        #1;
        check_val("exc_ctrl", 64'({pif.M_bubble, pif.set_cc}), 64'b10);
        step();
        pif.m_stat = S_AOK; pif.W_stat = S_HLT;
        step();
        check_val("halted", 64'(pif.halted), 64'd1);
        check_val("halt_ctrl", 64'({pif.F_stall, pif.D_stall, pif.W_stall, pif.M_bubble,
                                     pif.E_bubble, pif.D_bubble, pif.set_cc}), 64'b1111000);
        pif.W_stat = S_AOK; pif.f_predPC = 64'd99;
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_val("rst2_halted", 64'(pif.halted), 64'd0);
        check_val("rst2_pred", pif.F_predPC, RESET_PC);

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            reset        = ($urandom_range(0, 39) == 0);
            pif.f_predPC = {$urandom, $urandom};
            pif.M_icode  = rnd_icode();
            pif.W_icode  = rnd_icode();
            pif.D_icode  = rnd_icode();
            pif.E_icode  = rnd_icode();
            pif.M_Cnd    = 1'($urandom_range(0, 1));
            pif.e_Cnd    = 1'($urandom_range(0, 1));
            pif.M_valA   = {$urandom, $urandom};
            pif.W_valM   = {$urandom, $urandom};
            pif.E_dstM   = rnd_reg();
            pif.d_srcA   = rnd_reg();
            pif.d_srcB   = rnd_reg();
            pif.m_stat   = ($urandom_range(0, 9) == 0)  ? 3'($urandom_range(0, 7)) : S_AOK;
            pif.W_stat   = ($urandom_range(0, 29) == 0) ? 3'($urandom_range(0, 7)) : S_AOK;
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
